aqp_esp_uart_tx: RTL and testbench



---
 rtl/aqp_esp_uart_tx.sv | 138 +++++++++++++
 tb/tb_aqp_esp_uart_tx.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aqp_esp_uart_tx.sv
// rtl/aqp_esp_uart_tx.sv - 16-entry byte FIFO feeding an 8N1 UART transmitter toward the ESP32
// Optional CTS flow control enabled by defining ESP_UART_TX_CTS_EN.
module aqp_esp_uart_tx #(
  parameter int unsigned BAUD_DIV = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] wrdata,
  input  logic       wr_en,
  output logic       full,
  output logic       almost_full,
  output logic       empty,
  output logic       busy,
`ifdef ESP_UART_TX_CTS_EN
  input  logic       cts_n,
`endif
  output logic       txd
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_STOP} state_e;

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  logic [7:0]  mem [16];
  logic [3:0]  wridx_q, rdidx_q;
  logic [7:0]  rddata_q;
  logic [3:0]  count;
  logic        wr_accept, pop, cts_ok, baud_end;
  state_e      state_q;
  logic [7:0]  shreg_q;
  logic [15:0] baud_q;
  logic [2:0]  bit_q;
  logic        txd_q, busy_q;

  assign count       = wridx_q - rdidx_q;
  assign full        = (wridx_q + 4'd1) == rdidx_q;
  assign empty       = wridx_q == rdidx_q;
  assign almost_full = count >= 4'd8;
  assign wr_accept   = wr_en && !full;
  assign pop         = (state_q == S_IDLE) && !empty && cts_ok;
  assign baud_end    = baud_q == BAUD_LAST;
  assign txd         = txd_q;
  assign busy        = busy_q;

`ifdef ESP_UART_TX_CTS_EN
  logic cts_s1_q, cts_s2_q;

  // Resets to "not clear" so nothing leaves until the ESP actually grants CTS.
  always_ff @(posedge clk) begin
    if (reset) begin
      cts_s1_q <= 1'b1;
      cts_s2_q <= 1'b1;
    end else begin
      cts_s1_q <= cts_n;
      cts_s2_q <= cts_s1_q;
    end
  end

  assign cts_ok = !cts_s2_q;
`else
  assign cts_ok = 1'b1;
`endif

  // RAM contents are deliberately not reset; indices alone define validity.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wridx_q] <= wrdata;
    rddata_q <= mem[rdidx_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wridx_q <= '0;
      rdidx_q <= '0;
    end else begin
      if (wr_accept) wridx_q <= wridx_q + 4'd1;
      if (pop)       rdidx_q <= rdidx_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      busy_q <= wr_accept || !empty || (state_q != S_IDLE);
      case (state_q)
        S_IDLE: begin
          if (pop) state_q <= S_LOAD;
        end
        S_LOAD: begin
          shreg_q <= rddata_q;
          txd_q   <= 1'b0;
          baud_q  <= '0;
          bit_q   <= '0;
          state_q <= S_START;
        end
        S_START: begin
          if (baud_end) begin
            baud_q  <= '0;
            txd_q   <= shreg_q[0];
            state_q <= S_DATA;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        S_DATA: begin
          if (baud_end) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              txd_q   <= 1'b1;
              state_q <= S_STOP;
            end else begin
              txd_q   <= shreg_q[1];
              shreg_q <= {1'b0, shreg_q[7:1]};
              bit_q   <= bit_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        S_STOP: begin
          if (baud_end) begin
            baud_q  <= '0;
            state_q <= S_IDLE;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aqp_esp_uart_tx.sv
// tb/tb_aqp_esp_uart_tx.sv - directed self-checking bench for aqp_esp_uart_tx (BAUD_DIV=4)
module tb_aqp_esp_uart_tx;

  localparam int BD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wrdata = 8'h00;
  logic       full, almost_full, empty, busy, txd;
`ifdef ESP_UART_TX_CTS_EN
  logic       cts_n = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int w_cyc = 0;
  logic [7:0] got_byte [64];
  int         got_fall [64];
  int         got_n = 0;

  aqp_esp_uart_tx #(.BAUD_DIV(BD)) dut (
    .clk(clk),
    .reset(reset),
    .wrdata(wrdata),
    .wr_en(wr_en),
    .full(full),
    .almost_full(almost_full),
    .empty(empty),
    .busy(busy),
`ifdef ESP_UART_TX_CTS_EN
    .cts_n(cts_n),
`endif
    .txd(txd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Expected line level at offset rel from the start-bit fall.
  function automatic logic exp_bit(input logic [7:0] b, input int rel);
    if (rel < 0) return 1'b1;
    if (rel < BD) return 1'b0;
    if (rel < 9 * BD) return b[(rel - BD) / BD];
    return 1'b1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    wr_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic capture_frames(input int n, input int budget);
    logic [7:0] b;
    int waited;
    for (int f = 0; f < n; f++) begin
      waited = 0;
      while (txd !== 1'b0 && waited < budget) begin
        @(negedge clk);
        waited++;
      end
      if (txd !== 1'b0) begin
        tests++; fails++;
        $display("FAIL capture_timeout frame=%0d got=no_start exp=start_bit", f);
        return;
      end
      got_fall[got_n] = cyc;
      b = 8'h00;
      for (int r = 1; r <= 9 * BD + BD / 2; r++) begin
        @(negedge clk);
        if (r >= BD && r < 9 * BD && (r % BD) == BD / 2) b[(r - BD) / BD] = txd;
      end
      tests++;
      if (txd !== 1'b1) begin
        fails++;
        $display("FAIL stop_bit frame=%0d got=%b exp=1", f, txd);
      end
      got_byte[got_n] = b;
      got_n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({txd, full, almost_full, empty, busy} !== 5'b10010) begin
      fails++;
      $display("FAIL reset_state got=%b exp=10010", {txd, full, almost_full, empty, busy});
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single();
    @(negedge clk);
    wrdata = 8'h55; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    tests++;
    if (empty !== 1'b0) begin
      fails++;
      $display("FAIL single_empty got=%b exp=0", empty);
    end
    for (int k = 1; k <= 46; k++) begin
      if (k > 1) @(negedge clk);
      tests++;
      if (txd !== exp_bit(8'h55, k - 3)) begin
        fails++;
        $display("FAIL single_txd k=%0d got=%b exp=%b", k, txd, exp_bit(8'h55, k - 3));
      end
      if (k == 43 || k == 44) begin
        tests++;
        if (busy !== (k == 43)) begin
          fails++;
          $display("FAIL single_busy k=%0d got=%b exp=%b", k, busy, (k == 43));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [3];
    exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'hA3;
    got_n = 0;
    fork
      begin
        for (int m = 0; m < 4; m++) begin
          @(negedge clk);
          if (m == 0) w_cyc = cyc;
          wr_en = (m < 3);
          if (m < 3) wrdata = exp[m];
        end
      end
      capture_frames(3, 200);
    join
    tests++;
    if (got_n !== 3) begin
      fails++;
      $display("FAIL b2b_count got=%0d exp=3", got_n);
    end
    if (got_n > 0) begin
      tests++;
      if (got_fall[0] - w_cyc !== 3) begin
        fails++;
        $display("FAIL b2b_latency got=%0d exp=3", got_fall[0] - w_cyc);
      end
    end
    for (int i = 0; i < got_n && i < 3; i++) begin
      tests++;
      if (got_byte[i] !== exp[i]) begin
        fails++;
        $display("FAIL b2b_byte i=%0d got=%h exp=%h", i, got_byte[i], exp[i]);
      end
      if (i > 0) begin
        tests++;
        if (got_fall[i] - got_fall[i-1] !== 10 * BD + 2) begin
          fails++;
          $display("FAIL b2b_period i=%0d got=%0d exp=%0d", i, got_fall[i] - got_fall[i-1], 10 * BD + 2);
        end
      end
    end
    repeat (10) @(negedge clk);
    tests++;
    if ({busy, empty} !== 2'b01) begin
      fails++;
      $display("FAIL b2b_idle got=%b exp=01", {busy, empty});
    end
  endtask

  task automatic test_fill_full();
    int cnt;
    int starts;
    do_reset();
    got_n = 0;
    fork
      begin
        for (int m = 0; m <= 17; m++) begin
          @(negedge clk);
          if (m >= 2) begin
            cnt = (m - 1 > 15) ? 15 : m - 1;
            tests++;
            if ({almost_full, full} !== {cnt >= 8, cnt == 15}) begin
              fails++;
              $display("FAIL fill_flags m=%0d got=%b exp=%b", m, {almost_full, full}, {cnt >= 8, cnt == 15});
            end
          end
          wr_en = (m <= 16);
          wrdata = 8'(m + 1);
        end
      end
      capture_frames(16, 300);
    join
    tests++;
    if (got_n !== 16) begin
      fails++;
      $display("FAIL fill_count got=%0d exp=16", got_n);
    end
    for (int i = 0; i < got_n && i < 16; i++) begin
      tests++;
      if (got_byte[i] !== 8'(i + 1)) begin
        fails++;
        $display("FAIL fill_byte i=%0d got=%h exp=%h", i, got_byte[i], 8'(i + 1));
      end
    end
    starts = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (txd !== 1'b1) starts++;
    end
    tests++;
    if (starts !== 0 || empty !== 1'b1) begin
      fails++;
      $display("FAIL fill_drop got=low_cycles:%0d empty:%b exp=0,1", starts, empty);
    end
  endtask

  task automatic test_write_on_pop();
    int starts;
    do_reset();
    got_n = 0;
    fork
      begin
        for (int m = 0; m <= 46; m++) begin
          @(negedge clk);
          if (m >= 43 && m <= 45) begin
            tests++;
            if (full !== (m != 44)) begin
              fails++;
              $display("FAIL pop_full m=%0d got=%b exp=%b", m, full, (m != 44));
            end
          end
          wr_en = (m <= 45);
          if (m <= 15)      wrdata = 8'(8'h20 + m);
          else if (m <= 42) wrdata = 8'hC0;
          else              wrdata = 8'(8'hE1 + (m - 43));
        end
        wr_en = 1'b0;
      end
      capture_frames(17, 300);
    join
    tests++;
    if (got_n !== 17) begin
      fails++;
      $display("FAIL pop_count got=%0d exp=17", got_n);
    end
    for (int i = 0; i < got_n && i < 17; i++) begin
      tests++;
      if (got_byte[i] !== ((i < 16) ? 8'(8'h20 + i) : 8'hE2)) begin
        fails++;
        $display("FAIL pop_byte i=%0d got=%h exp=%h", i, got_byte[i], (i < 16) ? 8'(8'h20 + i) : 8'hE2);
      end
    end
    starts = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (txd !== 1'b1) starts++;
    end
    tests++;
    if (starts !== 0) begin
      fails++;
      $display("FAIL pop_extra got=%0d exp=0", starts);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] q [5];
    int starts;
    q[0] = 8'h0F; q[1] = 8'h11; q[2] = 8'h22; q[3] = 8'h33; q[4] = 8'h44;
    do_reset();
    for (int m = 0; m <= 21; m++) begin
      @(negedge clk);
      if (m == 10 || m == 18) begin
        tests++;
        if (txd !== exp_bit(8'h0F, m - 3)) begin
          fails++;
          $display("FAIL mid_pre m=%0d got=%b exp=%b", m, txd, exp_bit(8'h0F, m - 3));
        end
      end
      if (m == 21) begin
        tests++;
        if ({txd, empty, busy, full, almost_full} !== 5'b11000) begin
          fails++;
          $display("FAIL mid_reset got=%b exp=11000", {txd, empty, busy, full, almost_full});
        end
      end
      wr_en = (m < 5);
      if (m < 5) wrdata = q[m];
      reset = (m == 20);
    end
    starts = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) starts++;
    end
    tests++;
    if (starts !== 0) begin
      fails++;
      $display("FAIL mid_after got=%0d exp=0", starts);
    end
  endtask

`ifdef ESP_UART_TX_CTS_EN
  task automatic test_cts();
    int starts;
    cts_n = 1'b1;
    do_reset();
    starts = 0;
    for (int m = 0; m <= 160; m++) begin
      @(negedge clk);
      if (m == 30 || m == 33 || m == 153) begin
        tests++;
        if (txd !== 1'b1) begin
          fails++;
          $display("FAIL cts_hold m=%0d got=%b exp=1", m, txd);
        end
      end
      if (m == 34 || m == 154) begin
        tests++;
        if (txd !== 1'b0) begin
          fails++;
          $display("FAIL cts_start m=%0d got=%b exp=0", m, txd);
        end
      end
      if (m == 40 + 4 * BD) begin
        tests++;
        if (txd !== exp_bit(8'h5A, m - 34)) begin
          fails++;
          $display("FAIL cts_complete m=%0d got=%b exp=%b", m, txd, exp_bit(8'h5A, m - 34));
        end
      end
      if (m >= 74 && m <= 153 && txd !== 1'b1) starts++;
      wr_en = (m < 2);
      wrdata = (m == 0) ? 8'h5A : 8'hA5;
      if (m == 30)  cts_n = 1'b0;
      if (m == 40)  cts_n = 1'b1;
      if (m == 150) cts_n = 1'b0;
    end
    tests++;
    if (starts !== 0) begin
      fails++;
      $display("FAIL cts_blocked got=%0d exp=0", starts);
    end
    repeat (60) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fill_full();
    test_write_on_pop();
    test_reset_mid();
`ifdef ESP_UART_TX_CTS_EN
    test_cts();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
